// File: rtl/rep_link_pkg.sv
// Shared types and defaults for the triple-repetition serial link.
// Used by both the transmit encoder and the majority-voter receiver.
package rep_link_pkg;

  localparam int REP_COUNT  = 3;
  localparam int REP_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rep_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rep3_tx_encoder.sv
// Repetition-code transmitter: serialises a word LSB first,
// holding each bit for REP cycles for far-end majority voting.
module rep3_tx_encoder
  import rep_link_pkg::*;
#(
  parameter int DATA_W = REP_DATA_W,
  parameter int REP    = REP_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_first,
  output logic              busy
);

  localparam int RCW = cnt_w(REP);
  localparam int BCW = cnt_w(DATA_W);

  localparam logic [RCW-1:0] REP_LAST = RCW'(REP - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

  if (REP < 3 || (REP % 2) == 0) begin : g_bad_rep
    $error("rep3_tx_encoder: REP must be odd and >= 3");
  end

  if (DATA_W < 1) begin : g_bad_w
    $error("rep3_tx_encoder: DATA_W must be >= 1");
  end

  rep_state_e        state_q, state_d;
  logic [RCW-1:0]    rep_cnt_q, rep_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shifted;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_first_q, tx_first_d;
  logic              busy_q, busy_d;
  logic              rep_last;
  logic              bit_last;
  logic              frame_last;
  logic              accept;

  assign rep_last   = (rep_cnt_q == REP_LAST);
  assign bit_last   = (bit_cnt_q == BIT_LAST);
  assign frame_last = (state_q == SEND) && rep_last && bit_last;
  assign shifted    = shreg_q >> 1;

  assign in_ready = !rst && ((state_q == IDLE) || frame_last);
  assign accept   = in_valid && in_ready;

  // shreg_q[0] is always the bit currently on the wire
  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_bit_d   = 1'b0;
    tx_valid_d = 1'b0;
    tx_first_d = 1'b0;
    busy_d     = 1'b0;
    if (accept) begin
      state_d    = SEND;
      rep_cnt_d  = '0;
      bit_cnt_d  = '0;
      shreg_d    = in_data;
      tx_bit_d   = in_data[0];
      tx_valid_d = 1'b1;
      tx_first_d = 1'b1;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SEND: begin
          if (frame_last) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else if (rep_last) begin
            rep_cnt_d  = '0;
            bit_cnt_d  = bit_cnt_q + BCW'(1);
            shreg_d    = shifted;
            tx_bit_d   = shifted[0];
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            rep_cnt_d  = rep_cnt_q + RCW'(1);
            tx_bit_d   = shreg_q[0];
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rep_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_first_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      tx_first_q <= tx_first_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign tx_first = tx_first_q;
  assign busy     = busy_q;

endmodule
